// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencing controller: detects mul/div instructions, stalls the front end,
// issues a start pulse to the multdiv unit, waits for its result (with timeout) and produces a
// one-cycle register-file write-back.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] q_imem,
  input  logic        flush,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [15:0] md_count
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0] CntLast = 6'(TIMEOUT - 1);
  localparam logic [4:0] ExcRd   = 5'd30;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic        ctrl_mult_q, ctrl_div_q;
  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [15:0] md_count_q;

  logic md_instr;
  logic detect;
  logic complete;
  logic exc;

  // Decode: R-type opcode with ALU op mul (00110) or div (00111).
  assign md_instr = (q_imem[31:27] == 5'b00000) &&
                    ((q_imem[6:2] == 5'b00110) || (q_imem[6:2] == 5'b00111));
  assign detect   = (state_q == StIdle) && md_instr && !flush;

  // Next-state, stall and completion decode.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    complete = 1'b0;
    exc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = detect;
        if (detect) state_d = StBusy;
      end
      StBusy: begin
        stall = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else if ((cnt_q != 6'd0) && data_resultRDY) begin
          // First BUSY cycle is the start-pulse cycle, so RDY is ignored there.
          state_d  = StDone;
          complete = 1'b1;
          exc      = data_exception;
        end else if (cnt_q == CntLast) begin
          state_d  = StDone;
          complete = 1'b1;
          exc      = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Reset holds the FSM in IDLE, but a live instruction must not raise stall meanwhile.
    if (!reset) stall = 1'b0;
  end

  // State, cycle counter, latched operation and start pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      rd_q        <= 5'd0;
      is_div_q    <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (state_q == StBusy) ? cnt_q + 6'd1 : 6'd0;
      ctrl_mult_q <= detect && !q_imem[2];
      ctrl_div_q  <= detect && q_imem[2];
      if (detect) begin
        rd_q     <= q_imem[26:22];
        is_div_q <= q_imem[2];
      end
    end
  end

  // Write-back registers: loaded on the BUSY->DONE transition so they are valid during DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wb_en_q <= complete && (exc || (rd_q != 5'd0));
      if (complete) begin
        wb_rd_q   <= exc ? ExcRd : rd_q;
        wb_data_q <= exc ? (is_div_q ? 32'd5 : 32'd4) : data_result;
      end
    end
  end

  // Completed-operation counter, saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_count_q <= 16'd0;
    end else if ((state_q == StDone) && (md_count_q != 16'hFFFF)) begin
      md_count_q <= md_count_q + 16'd1;
    end
  end

  assign ctrl_MULT = ctrl_mult_q;
  assign ctrl_DIV  = ctrl_div_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign md_count  = md_count_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
module tb_multdiv_ctrl;

  localparam int unsigned TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic [31:0] q_imem;
  logic        flush;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] md_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters sampled on the falling edge.
  int n_stall = 0, n_mult = 0, n_div = 0, n_both = 0, n_wb = 0;
  int s_stall, s_mult, s_div, s_wb;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .q_imem         (q_imem),
    .flush          (flush),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_result    (data_result),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .stall          (stall),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .md_count       (md_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (stall)                 n_stall++;
    if (ctrl_MULT)             n_mult++;
    if (ctrl_DIV)              n_div++;
    if (ctrl_MULT && ctrl_DIV) n_both++;
    if (wb_en)                 n_wb++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    s_stall = n_stall;
    s_mult  = n_mult;
    s_div   = n_div;
    s_wb    = n_wb;
  endtask

  function automatic logic [31:0] md_op(input logic [4:0] rd, input logic div);
    return {5'b00000, rd, 15'd0, (div ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  initial begin
    reset          = 1'b0;
    q_imem         = md_op(5'd5, 1'b0);
    flush          = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    data_result    = 32'd0;
    #3;
    // Reset state, with an md instruction present.
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mult",  32'(ctrl_MULT), 32'd0);
    check("rst_div",   32'(ctrl_DIV), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wbdat", wb_data, 32'd0);
    check("rst_count", 32'(md_count), 32'd0);
    q_imem = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    tick();

    // mul rd=5, RDY three cycles after the start pulse.
    snap();
    q_imem = md_op(5'd5, 1'b0);
    #1 check("t1_detect_stall", 32'(stall), 32'd1);
    tick();                      // BUSY c0
    q_imem = 32'd0;
    #1 check("t1_pulse", 32'(ctrl_MULT), 32'd1);
    tick();                      // c1
    tick();                      // c2
    tick();                      // c3
    data_resultRDY = 1'b1;
    data_result    = 32'h0000_0042;
    tick();                      // DONE
    data_resultRDY = 1'b0;
    #1;
    check("t1_wb_en", 32'(wb_en), 32'd1);
    check("t1_wb_rd", 32'(wb_rd), 32'd5);
    check("t1_wb_data", wb_data, 32'h42);
    check("t1_done_stall", 32'(stall), 32'd0);
    tick();                      // IDLE
    check("t1_count", 32'(md_count), 32'd1);
    check("t1_wb_en_off", 32'(wb_en), 32'd0);
    check("t1_wb_hold", wb_data, 32'h42);
    check("t1_stall_cyc", 32'(n_stall - s_stall), 32'd5);
    check("t1_mult_cnt", 32'(n_mult - s_mult), 32'd1);
    check("t1_div_cnt", 32'(n_div - s_div), 32'd0);
    check("t1_wb_cnt", 32'(n_wb - s_wb), 32'd1);

    // div rd=7 with exception; RDY held from the pulse cycle must be ignored there.
    snap();
    q_imem = md_op(5'd7, 1'b1);
    tick();                      // c0
    q_imem         = 32'd0;
    data_resultRDY = 1'b1;
    data_exception = 1'b1;
    #1 check("t2_div_pulse", 32'(ctrl_DIV), 32'd1);
    tick();                      // c1: RDY accepted here
    #1;
    check("t2_rdy_ignored", 32'(wb_en), 32'd0);
    check("t2_busy_stall", 32'(stall), 32'd1);
    tick();                      // DONE
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    #1;
    check("t2_wb_en", 32'(wb_en), 32'd1);
    check("t2_wb_rd", 32'(wb_rd), 32'd30);
    check("t2_wb_data", wb_data, 32'd5);
    tick();
    check("t2_count", 32'(md_count), 32'd2);
    check("t2_no_mult", 32'(n_mult - s_mult), 32'd0);

    // mul with no RDY: timeout after exactly TIMEOUT BUSY cycles.
    snap();
    q_imem = md_op(5'd3, 1'b0);
    tick();                      // c0
    q_imem = 32'd0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    #1 check("t3_last_busy", 32'(wb_en), 32'd0);
    tick();                      // DONE
    #1;
    check("t3_wb_en", 32'(wb_en), 32'd1);
    check("t3_wb_rd", 32'(wb_rd), 32'd30);
    check("t3_wb_data", wb_data, 32'd4);
    tick();
    check("t3_count", 32'(md_count), 32'd3);
    check("t3_stall_cyc", 32'(n_stall - s_stall), 32'(TIMEOUT + 1));

    // flush in the same BUSY cycle as RDY.
    snap();
    q_imem = md_op(5'd9, 1'b0);
    tick();                      // c0
    q_imem = 32'd0;
    tick();                      // c1
    data_resultRDY = 1'b1;
    flush          = 1'b1;
    data_result    = 32'hDEAD;
    tick();                      // IDLE
    data_resultRDY = 1'b0;
    flush          = 1'b0;
    #1 check("t4_stall", 32'(stall), 32'd0);
    tick();
    tick();
    check("t4_count", 32'(md_count), 32'd3);
    check("t4_wb_cnt", 32'(n_wb - s_wb), 32'd0);
    check("t4_wb_rd_hold", 32'(wb_rd), 32'd30);

    // mul rd=0 normal completion: no write, still counted.
    snap();
    q_imem = md_op(5'd0, 1'b0);
    tick();
    q_imem = 32'd0;
    tick();
    data_resultRDY = 1'b1;
    data_result    = 32'h1234;
    tick();                      // DONE
    data_resultRDY = 1'b0;
    tick();
    check("t5_wb_cnt", 32'(n_wb - s_wb), 32'd0);
    check("t5_count", 32'(md_count), 32'd4);

    // Reset mid-BUSY, then two back-to-back muls.
    q_imem = md_op(5'd4, 1'b0);
    tick();                      // c0
    q_imem = 32'd0;
    tick();                      // c1
    q_imem = md_op(5'd6, 1'b0);
    reset  = 1'b0;
    #1;
    check("t6_rst_stall", 32'(stall), 32'd0);
    check("t6_rst_wb_en", 32'(wb_en), 32'd0);
    check("t6_rst_wb_rd", 32'(wb_rd), 32'd0);
    check("t6_rst_wbdat", wb_data, 32'd0);
    check("t6_rst_count", 32'(md_count), 32'd0);
    check("t6_rst_pulse", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
    @(negedge clock);
    snap();
    reset = 1'b1;
    tick();                      // c0, first op
    check("t6_pulse1", 32'(ctrl_MULT), 32'd1);
    tick();                      // c1
    data_resultRDY = 1'b1;
    data_result    = 32'h11;
    tick();                      // DONE
    data_resultRDY = 1'b0;
    #1;
    check("t6_done1_wb", 32'(wb_en), 32'd1);
    check("t6_done_nostall", 32'(stall), 32'd0);
    tick();                      // IDLE, instruction still present
    check("t6_no_retrig", 32'(ctrl_MULT), 32'd0);
    check("t6_redetect", 32'(stall), 32'd1);
    tick();                      // c0, second op
    check("t6_pulse2", 32'(ctrl_MULT), 32'd1);
    q_imem = 32'd0;
    tick();                      // c1
    data_resultRDY = 1'b1;
    data_result    = 32'h22;
    tick();                      // DONE
    data_resultRDY = 1'b0;
    #1 check("t6_wb_data2", wb_data, 32'h22);
    tick();
    tick();
    check("t6_count", 32'(md_count), 32'd2);
    check("t6_mult_cnt", 32'(n_mult - s_mult), 32'd2);
    check("never_both", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
